matrix_addr_gen: RTL and testbench

Parametrised successor to the matrix read/write controller. Converts top-level matrix read/write strobes into a banked RAM select, a bank-local address and per-bank write enables. It uses independent 2-D read and write counters. Adds generic widths and bank count, a column-major (transpose) read mode, read/write arbitration with a stall flag, pass-complete pulses and a synchronous restart. Sits between the accelerator command logic and the matrix RAM banks.

---
 rtl/matrix_addr_gen_if.sv | 34 +++
 rtl/matrix_addr_gen.sv | 114 +++++++++++
 tb/tb_matrix_addr_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_addr_gen_if.sv
// Command/status bundle between accelerator command logic and the matrix address generator.
// The master side drives strobes and configuration; the slave side returns RAM controls.
interface matrix_addr_gen_if #(
    parameter int ROW_W     = 10,
    parameter int COL_W     = 10,
    parameter int BANK_BITS = 4
);
    localparam int NBANK  = 2**BANK_BITS;
    localparam int ADDR_W = ROW_W - BANK_BITS + COL_W;

    logic [ROW_W-1:0]  cfg_rows;
    logic [COL_W-1:0]  cfg_cols;
    logic              we;
    logic              re;
    logic              rd_mode;
    logic              clr;
    logic [NBANK-1:0]  ram_sel;
    logic [ADDR_W-1:0] a;
    logic [NBANK-1:0]  we_out;
    logic              rd_valid;
    logic              rd_stall;
    logic              wr_done;
    logic              rd_done;

    modport master (
        output cfg_rows, cfg_cols, we, re, rd_mode, clr,
        input  ram_sel, a, we_out, rd_valid, rd_stall, wr_done, rd_done
    );

    modport slave (
        input  cfg_rows, cfg_cols, we, re, rd_mode, clr,
        output ram_sel, a, we_out, rd_valid, rd_stall, wr_done, rd_done
    );
endinterface

// File: rtl/matrix_addr_gen.sv
// Banked matrix RAM address generator: independent 2-D read/write walkers, write-priority
// arbitration, optional column-major reads, one-cycle registered RAM controls.
module matrix_addr_gen #(
    parameter int ROW_W     = 10,
    parameter int COL_W     = 10,
    parameter int BANK_BITS = 4
) (
    input  logic            CLK,
    input  logic            RST_L,
    matrix_addr_gen_if.slave bus
);
    localparam int NBANK  = 2**BANK_BITS;
    localparam int LOC_W  = ROW_W - BANK_BITS;
    localparam int ADDR_W = LOC_W + COL_W;

    logic [ROW_W-1:0]     r_wr_row, r_rd_row;
    logic [COL_W-1:0]     r_wr_col, r_rd_col;
    logic                 r_mode;

    logic                 w_wr_acc, w_rd_acc, w_stall;
    logic                 w_rd_origin, w_mode;
    logic                 w_wr_last, w_rd_last;
    logic [ROW_W-1:0]     w_wr_row_nx, w_rd_row_nx, w_acc_row;
    logic [COL_W-1:0]     w_wr_col_nx, w_rd_col_nx, w_acc_col;
    logic [BANK_BITS-1:0] w_bank;
    logic [NBANK-1:0]     w_onehot;

    always_comb begin
        w_wr_acc    = bus.we & ~bus.clr;
        w_rd_acc    = bus.re & ~bus.we & ~bus.clr;
        w_stall     = bus.re & bus.we & ~bus.clr;
        w_rd_origin = (r_rd_row == '0) && (r_rd_col == '0);
        // The read at the origin both latches the mode and steps using it.
        w_mode      = w_rd_origin ? bus.rd_mode : r_mode;
        w_wr_last   = (r_wr_row == bus.cfg_rows) && (r_wr_col == bus.cfg_cols);
        w_rd_last   = (r_rd_row == bus.cfg_rows) && (r_rd_col == bus.cfg_cols);

        // Write walker, row-major. >= keeps a counter stranded past a shrunk cfg from running away.
        w_wr_row_nx = r_wr_row;
        w_wr_col_nx = r_wr_col + 1'b1;
        if (r_wr_col >= bus.cfg_cols) begin
            w_wr_col_nx = '0;
            w_wr_row_nx = (r_wr_row >= bus.cfg_rows) ? '0 : r_wr_row + 1'b1;
        end

        w_rd_row_nx = r_rd_row;
        w_rd_col_nx = r_rd_col;
        if (!w_mode) begin
            w_rd_col_nx = r_rd_col + 1'b1;
            if (r_rd_col >= bus.cfg_cols) begin
                w_rd_col_nx = '0;
                w_rd_row_nx = (r_rd_row >= bus.cfg_rows) ? '0 : r_rd_row + 1'b1;
            end
        end else begin
            w_rd_row_nx = r_rd_row + 1'b1;
            if (r_rd_row >= bus.cfg_rows) begin
                w_rd_row_nx = '0;
                w_rd_col_nx = (r_rd_col >= bus.cfg_cols) ? '0 : r_rd_col + 1'b1;
            end
        end

        w_acc_row = w_wr_acc ? r_wr_row : r_rd_row;
        w_acc_col = w_wr_acc ? r_wr_col : r_rd_col;
        w_bank    = w_acc_row[ROW_W-1 -: BANK_BITS];
        w_onehot  = '0;
        w_onehot[w_bank] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_rd_row <= '0;
            r_rd_col <= '0;
            r_mode   <= 1'b0;
        end else if (bus.clr) begin
            r_wr_row <= '0;
            r_wr_col <= '0;
            r_rd_row <= '0;
            r_rd_col <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_row <= w_wr_row_nx;
                r_wr_col <= w_wr_col_nx;
            end
            if (w_rd_acc) begin
                r_rd_row <= w_rd_row_nx;
                r_rd_col <= w_rd_col_nx;
                if (w_rd_origin) r_mode <= bus.rd_mode;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            bus.ram_sel  <= '0;
            bus.we_out   <= '0;
            bus.a        <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_stall <= 1'b0;
            bus.wr_done  <= 1'b0;
            bus.rd_done  <= 1'b0;
        end else begin
            bus.ram_sel  <= (w_wr_acc | w_rd_acc) ? w_onehot : '0;
            bus.we_out   <= w_wr_acc ? w_onehot : '0;
            if (w_wr_acc | w_rd_acc)
                bus.a    <= ADDR_W'({w_acc_row[LOC_W-1:0], w_acc_col});
            bus.rd_valid <= w_rd_acc;
            bus.rd_stall <= w_stall;
            bus.wr_done  <= w_wr_acc & w_wr_last;
            bus.rd_done  <= w_rd_acc & w_rd_last;
        end
    end
endmodule

// File: tb/tb_matrix_addr_gen.sv
// Directed bench for matrix_addr_gen at default widths (16 banks, 16-bit bank-local address).
module tb_matrix_addr_gen;
    localparam int ROW_W = 10, COL_W = 10, BANK_BITS = 4;
    localparam int NBANK = 16, ADDR_W = 16;

    logic CLK = 1'b0;
    logic RST_L = 1'b1;
    int   checks = 0;
    int   errors = 0;

    matrix_addr_gen_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_BITS(BANK_BITS)) bus ();
    matrix_addr_gen #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_BITS(BANK_BITS)) dut (
        .CLK(CLK), .RST_L(RST_L), .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        bus.we = 1'b0; bus.re = 1'b0; bus.clr = 1'b0;
    endtask

    task automatic do_clr;
        bus.we = 1'b0; bus.re = 1'b0; bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    task automatic test_reset;
        bus.cfg_rows = '0; bus.cfg_cols = '0; bus.rd_mode = 1'b0;
        idle();
        #2 RST_L = 1'b0;
        tick(); tick();
        checks++;
        if (bus.a !== 16'd0) begin
            errors++; $display("FAIL reset_a: got %0h want 0", bus.a);
        end
        checks++;
        if ({bus.ram_sel, bus.we_out, bus.rd_valid, bus.rd_stall, bus.wr_done, bus.rd_done} !== 36'd0) begin
            errors++; $display("FAIL reset_ctl: sel=%h we_out=%h rv=%b rs=%b wd=%b rd=%b want all 0",
                bus.ram_sel, bus.we_out, bus.rd_valid, bus.rd_stall, bus.wr_done, bus.rd_done);
        end
        RST_L = 1'b1;
        tick();
    endtask

    task automatic test_row_major;
        int exp_a [7] = '{0, 1, 2, 1024, 1025, 1026, 0};
        bus.cfg_rows = 10'd1; bus.cfg_cols = 10'd2;
        for (int i = 0; i < 7; i++) begin
            bus.we = 1'b1;
            tick();
            checks++;
            if (bus.a !== 16'(exp_a[i])) begin
                errors++; $display("FAIL row_major_a[%0d]: got %0d want %0d", i, bus.a, exp_a[i]);
            end
            checks++;
            if (bus.ram_sel !== 16'h0001 || bus.we_out !== 16'h0001 || bus.rd_valid !== 1'b0) begin
                errors++; $display("FAIL row_major_sel[%0d]: sel=%h we_out=%h rv=%b want 0001 0001 0",
                    i, bus.ram_sel, bus.we_out, bus.rd_valid);
            end
            checks++;
            if (bus.wr_done !== (i == 5)) begin
                errors++; $display("FAIL row_major_done[%0d]: got %b want %b", i, bus.wr_done, (i == 5));
            end
        end
        idle();
    endtask

    task automatic test_clr;
        bus.cfg_rows = 10'd1; bus.cfg_cols = 10'd2;
        do_clr();
        for (int i = 0; i < 3; i++) begin
            bus.we = 1'b1;
            tick();
            checks++;
            if (bus.a !== 16'(i)) begin
                errors++; $display("FAIL clr_pre_a[%0d]: got %0d want %0d", i, bus.a, i);
            end
        end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        checks++;
        if (bus.ram_sel !== 16'h0 || bus.we_out !== 16'h0 || bus.wr_done !== 1'b0) begin
            errors++; $display("FAIL clr_cycle: sel=%h we_out=%h wd=%b want 0 0 0", bus.ram_sel, bus.we_out, bus.wr_done);
        end
        checks++;
        if (bus.a !== 16'd2) begin
            errors++; $display("FAIL clr_a_hold: got %0d want 2", bus.a);
        end
        tick();
        checks++;
        if (bus.a !== 16'd0 || bus.we_out !== 16'h0001 || bus.wr_done !== 1'b0) begin
            errors++; $display("FAIL clr_restart: a=%0d we_out=%h wd=%b want 0 0001 0", bus.a, bus.we_out, bus.wr_done);
        end
        idle();
    endtask

    task automatic test_bank_crossing;
        bus.cfg_rows = 10'd127; bus.cfg_cols = 10'd0;
        do_clr();
        for (int i = 0; i < 65; i++) begin
            bus.we = 1'b1;
            tick();
            if (i < 64) begin
                checks++;
                if (bus.we_out !== 16'h0001 || bus.ram_sel !== 16'h0001 || bus.a !== 16'(i * 1024)) begin
                    errors++; $display("FAIL bank0[%0d]: sel=%h we_out=%h a=%0d want 0001 0001 %0d",
                        i, bus.ram_sel, bus.we_out, bus.a, i * 1024);
                end
            end else begin
                checks++;
                if (bus.we_out !== 16'h0002 || bus.ram_sel !== 16'h0002 || bus.a !== 16'd0) begin
                    errors++; $display("FAIL bank1: sel=%h we_out=%h a=%0d want 0002 0002 0",
                        bus.ram_sel, bus.we_out, bus.a);
                end
            end
        end
        idle();
    endtask

    task automatic test_transpose;
        int exp_a [4] = '{0, 1024, 1, 1025};
        bus.cfg_rows = 10'd1; bus.cfg_cols = 10'd1; bus.rd_mode = 1'b1;
        do_clr();
        for (int i = 0; i < 4; i++) begin
            bus.re = 1'b1;
            tick();
            if (i == 0) bus.rd_mode = 1'b0;
            checks++;
            if (bus.a !== 16'(exp_a[i])) begin
                errors++; $display("FAIL transpose_a[%0d]: got %0d want %0d", i, bus.a, exp_a[i]);
            end
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.we_out !== 16'h0 || bus.ram_sel !== 16'h0001) begin
                errors++; $display("FAIL transpose_ctl[%0d]: rv=%b we_out=%h sel=%h want 1 0 0001",
                    i, bus.rd_valid, bus.we_out, bus.ram_sel);
            end
            checks++;
            if (bus.rd_done !== (i == 3)) begin
                errors++; $display("FAIL transpose_done[%0d]: got %b want %b", i, bus.rd_done, (i == 3));
            end
        end
        idle();
    endtask

    task automatic test_collision;
        bus.cfg_rows = 10'd1; bus.cfg_cols = 10'd1; bus.rd_mode = 1'b0;
        do_clr();
        bus.re = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.a !== 16'd1 || bus.rd_valid !== 1'b1) begin
            errors++; $display("FAIL coll_pre: a=%0d rv=%b want 1 1", bus.a, bus.rd_valid);
        end
        bus.we = 1'b1;
        tick();
        checks++;
        if (bus.we_out !== 16'h0001 || bus.rd_stall !== 1'b1 || bus.rd_valid !== 1'b0 || bus.a !== 16'd0) begin
            errors++; $display("FAIL coll_stall: we_out=%h rs=%b rv=%b a=%0d want 0001 1 0 0",
                bus.we_out, bus.rd_stall, bus.rd_valid, bus.a);
        end
        bus.we = 1'b0;
        tick();
        checks++;
        if (bus.a !== 16'd1024 || bus.rd_valid !== 1'b1 || bus.rd_stall !== 1'b0 || bus.we_out !== 16'h0) begin
            errors++; $display("FAIL coll_retry: a=%0d rv=%b rs=%b we_out=%h want 1024 1 0 0",
                bus.a, bus.rd_valid, bus.rd_stall, bus.we_out);
        end
        tick();
        checks++;
        if (bus.a !== 16'd1025 || bus.rd_done !== 1'b1) begin
            errors++; $display("FAIL coll_last: a=%0d rd_done=%b want 1025 1", bus.a, bus.rd_done);
        end
        idle();
    endtask

    task automatic test_async_reset;
        bus.cfg_rows = 10'd1; bus.cfg_cols = 10'd2; bus.rd_mode = 1'b0;
        do_clr();
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0; bus.we = 1'b1;
        tick();
        tick();
        bus.we = 1'b0;
        checks++;
        if (bus.a !== 16'd1 || bus.ram_sel !== 16'h0001) begin
            errors++; $display("FAIL arst_pre: a=%0d sel=%h want 1 0001", bus.a, bus.ram_sel);
        end
        #2 RST_L = 1'b0;
        #1;
        checks++;
        if (bus.a !== 16'd0 || bus.ram_sel !== 16'h0 || bus.we_out !== 16'h0 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL arst_now: a=%0d sel=%h we_out=%h rv=%b want all 0",
                bus.a, bus.ram_sel, bus.we_out, bus.rd_valid);
        end
        #2 RST_L = 1'b1;
        tick();
        bus.re = 1'b1;
        tick();
        checks++;
        if (bus.a !== 16'd0 || bus.rd_valid !== 1'b1) begin
            errors++; $display("FAIL arst_rd0: a=%0d rv=%b want 0 1", bus.a, bus.rd_valid);
        end
        tick();
        checks++;
        if (bus.a !== 16'd1) begin
            errors++; $display("FAIL arst_rd1: a=%0d want 1", bus.a);
        end
        bus.re = 1'b0; bus.we = 1'b1;
        tick();
        checks++;
        if (bus.a !== 16'd0 || bus.we_out !== 16'h0001) begin
            errors++; $display("FAIL arst_wr0: a=%0d we_out=%h want 0 0001", bus.a, bus.we_out);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_row_major();
        test_clr();
        test_bank_crossing();
        test_transpose();
        test_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
